// File: rtl/bcast_if.sv
// dti_s_if: valid/ready data stream carrying W-bit words.
// The producer drives data/valid; the consumer drives ready.
interface dti_s_if #(
   parameter int W = 16
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport producer (
      output data,
      output valid,
      input  ready
   );

   modport consumer (
      input  data,
      input  valid,
      output ready
   );

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/bcast.sv
// bcast: fans one stream out to two independently resized branches.
// Define BCAST_OUT_REG_EN to register the shared datum (1-cycle latency).
module bcast #(
   parameter int DIN        = 16,
   parameter int DOUT0      = 16,
   parameter int DOUT1      = 16,
   parameter int DIN_SIGNED = 0
) (
   input  logic      clk,
   input  logic      rst,
   dti_s_if.consumer din,
   dti_s_if.producer dout0,
   dti_s_if.producer dout1
);

   logic [DIN-1:0]   w_src;
   logic             w_fill;
   logic [DOUT0-1:0] w_d0;
   logic [DOUT1-1:0] w_d1;
   logic             w_v0;
   logic             w_v1;
   logic             w_hs0;
   logic             w_hs1;
   logic             w_rdy;
   logic             w_in_hs;

   assign w_fill = (DIN_SIGNED != 0) ? w_src[DIN-1] : 1'b0;

   generate
      if (DOUT0 > DIN) begin : g_ext0
         assign w_d0 = {{(DOUT0-DIN){w_fill}}, w_src};
      end else begin : g_trn0
         assign w_d0 = w_src[DOUT0-1:0];
      end
      if (DOUT1 > DIN) begin : g_ext1
         assign w_d1 = {{(DOUT1-DIN){w_fill}}, w_src};
      end else begin : g_trn1
         assign w_d1 = w_src[DOUT1-1:0];
      end
   endgenerate

   assign dout0.data  = w_d0;
   assign dout1.data  = w_d1;
   assign dout0.valid = w_v0;
   assign dout1.valid = w_v1;
   assign din.ready   = w_rdy;

   assign w_hs0   = w_v0 & dout0.ready;
   assign w_hs1   = w_v1 & dout1.ready;
   assign w_in_hs = din.valid & w_rdy;

`ifdef BCAST_OUT_REG_EN
   logic [DIN-1:0] r_data;
   logic           r_vld0;
   logic           r_vld1;

   assign w_src = r_data;
   assign w_v0  = r_vld0;
   assign w_v1  = r_vld1;
   assign w_rdy = (~r_vld0 | w_hs0) & (~r_vld1 | w_hs1);

   // Load on input handshake; each branch valid drops once it is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_vld0 <= 1'b0;
         r_vld1 <= 1'b0;
      end else if (w_in_hs) begin
         r_data <= din.data;
         r_vld0 <= 1'b1;
         r_vld1 <= 1'b1;
      end else begin
         if (w_hs0) r_vld0 <= 1'b0;
         if (w_hs1) r_vld1 <= 1'b0;
      end
   end
`else
   logic r_done0;
   logic r_done1;
   logic w_done0;
   logic w_done1;

   // Flags read as clear during reset so valids follow din.valid.
   assign w_done0 = r_done0 & ~rst;
   assign w_done1 = r_done1 & ~rst;

   assign w_src = din.data;
   assign w_v0  = din.valid & ~w_done0;
   assign w_v1  = din.valid & ~w_done1;
   assign w_rdy = (w_done0 | w_hs0) & (w_done1 | w_hs1);

   // Remember which branch already took the current datum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
      end else if (w_in_hs) begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
      end else begin
         r_done0 <= r_done0 | w_hs0;
         r_done1 <= r_done1 | w_hs1;
      end
   end
`endif

endmodule

// File: tb/tb_bcast.sv
// tb_bcast: signed and unsigned bcast instances on shared stimulus,
// scoreboarded per branch, with directed timing checks.
module tb_bcast;

   logic       clk = 1'b0;
   logic       rst;
   logic       r_vld;
   logic [7:0] r_dat;
   logic       r_rdy0;
   logic       r_rdy1;

   int n_run  = 0;
   int n_fail = 0;

   logic [31:0] seed = 32'h1ACE_B00C;

   logic [15:0] q0s[$];
   logic [15:0] q1s[$];
   logic [15:0] q0u[$];
   logic [15:0] q1u[$];

   always #5 clk = ~clk;

   dti_s_if #(.W(8))  di_s ();
   dti_s_if #(.W(16)) d0_s ();
   dti_s_if #(.W(4))  d1_s ();
   dti_s_if #(.W(8))  di_u ();
   dti_s_if #(.W(16)) d0_u ();
   dti_s_if #(.W(4))  d1_u ();

   assign di_s.valid = r_vld;
   assign di_s.data  = r_dat;
   assign d0_s.ready = r_rdy0;
   assign d1_s.ready = r_rdy1;
   assign di_u.valid = r_vld;
   assign di_u.data  = r_dat;
   assign d0_u.ready = r_rdy0;
   assign d1_u.ready = r_rdy1;

   bcast #(
      .DIN(8), .DOUT0(16), .DOUT1(4), .DIN_SIGNED(1)
   ) u_s (
      .clk(clk), .rst(rst),
      .din(di_s), .dout0(d0_s), .dout1(d1_s)
   );

   bcast #(
      .DIN(8), .DOUT0(16), .DOUT1(4), .DIN_SIGNED(0)
   ) u_u (
      .clk(clk), .rst(rst),
      .din(di_u), .dout0(d0_u), .dout1(d1_u)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd(output logic b);
      seed = seed ^ (seed << 13);
      seed = seed ^ (seed >> 17);
      seed = seed ^ (seed << 5);
      b = seed[3];
   endtask

   // Expected per-branch values for one datum, both signedness variants.
   task automatic push(input logic [7:0] d);
      q0s.push_back({{8{d[7]}}, d});
      q1s.push_back({12'h000, d[3:0]});
      q0u.push_back({8'h00, d});
      q1u.push_back({12'h000, d[3:0]});
   endtask

   // Scoreboard: every output handshake must match the next expected datum.
   always @(negedge clk) begin
      if (!rst) begin
         if (d0_s.valid && d0_s.ready) begin
            chk("d0s_avail", 32'(q0s.size() != 0), 1);
            if (q0s.size() != 0) chk("d0s_data", d0_s.data, q0s.pop_front());
         end
         if (d1_s.valid && d1_s.ready) begin
            chk("d1s_avail", 32'(q1s.size() != 0), 1);
            if (q1s.size() != 0) chk("d1s_data", d1_s.data, q1s.pop_front());
         end
         if (d0_u.valid && d0_u.ready) begin
            chk("d0u_avail", 32'(q0u.size() != 0), 1);
            if (q0u.size() != 0) chk("d0u_data", d0_u.data, q0u.pop_front());
         end
         if (d1_u.valid && d1_u.ready) begin
            chk("d1u_avail", 32'(q1u.size() != 0), 1);
            if (q1u.size() != 0) chk("d1u_data", d1_u.data, q1u.pop_front());
         end
      end
   end

   // Present one datum with random branch readies until din accepts it.
   task automatic send(input logic [7:0] d);
      logic acc;
      logic b;
      int   t;
      acc = 1'b0;
      t = 0;
      push(d);
      r_dat = d;
      r_vld = 1'b1;
      while (!acc && t < 60) begin
         rnd(b);
         r_rdy0 = b;
         rnd(b);
         r_rdy1 = b;
         @(negedge clk);
         acc = di_s.ready;
         chk("send_rdy_match", di_u.ready, di_s.ready);
         tick();
         t++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      r_vld = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      r_vld  = 1'b0;
      r_dat  = 8'h00;
      r_rdy0 = 1'b0;
      r_rdy1 = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_v0s", d0_s.valid, 0);
      chk("rst_v1s", d1_s.valid, 0);
      chk("rst_v0u", d0_u.valid, 0);
      tick();
      rst = 1'b0;

`ifndef BCAST_OUT_REG_EN
      // Same-cycle broadcast with extension and truncation.
      push(8'hA5);
      r_dat = 8'hA5; r_vld = 1'b1;
      r_rdy0 = 1'b1; r_rdy1 = 1'b1;
      @(negedge clk);
      chk("t1_rdy", di_s.ready, 1);
      chk("t1_v0", d0_s.valid, 1);
      chk("t1_v1", d1_s.valid, 1);
      chk("t1_d0s", d0_s.data, 32'hFFA5);
      chk("t1_d1s", d1_s.data, 32'h5);
      chk("t1_d0u", d0_u.data, 32'h00A5);
      chk("t1_d1u", d1_u.data, 32'h5);
      tick();

      // Branch 1 stalls for three cycles.
      push(8'h3C);
      r_dat = 8'h3C;
      r_rdy0 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         r_rdy1 = (c == 3);
         @(negedge clk);
         chk($sformatf("st_v0_c%0d", c), d0_s.valid, 32'(c == 0));
         chk($sformatf("st_rdy_c%0d", c), di_s.ready, 32'(c == 3));
         tick();
      end
      push(8'h3D);
      r_dat = 8'h3D;
      r_rdy0 = 1'b1; r_rdy1 = 1'b1;
      @(negedge clk);
      chk("st_c4_v0", d0_s.valid, 1);
      chk("st_c4_v1", d1_s.valid, 1);
      chk("st_c4_d0", d0_s.data, 32'h003D);
      chk("st_c4_rdy", di_s.ready, 1);
      tick();

      // Reset after a partial delivery re-presents the datum.
      push(8'h33);
      r_dat = 8'h33;
      r_rdy0 = 1'b1; r_rdy1 = 1'b0;
      @(negedge clk);
      chk("rr_partial_rdy", di_s.ready, 0);
      tick();
      r_rdy0 = 1'b0;
      rst = 1'b1;
      q0s.push_back(16'h0033);
      q0u.push_back(16'h0033);
      @(negedge clk);
      chk("rr_in_rst_v0", d0_s.valid, 1);
      chk("rr_in_rst_v1", d1_s.valid, 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rr_post_v0", d0_s.valid, 1);
      chk("rr_post_v1", d1_s.valid, 1);
      chk("rr_post_d0", d0_s.data, 32'h0033);
      chk("rr_post_d1", d1_u.data, 32'h3);
      tick();
      r_rdy0 = 1'b1; r_rdy1 = 1'b1;
      @(negedge clk);
      chk("rr_done_rdy", di_s.ready, 1);
      tick();
      r_vld = 1'b0;
`else
      // One-cycle latency through the output register.
      push(8'h11);
      r_dat = 8'h11; r_vld = 1'b1;
      r_rdy0 = 1'b1; r_rdy1 = 1'b1;
      @(negedge clk);
      chk("l1_rdy", di_s.ready, 1);
      chk("l1_v0_early", d0_s.valid, 0);
      tick();
      push(8'hA5);
      r_dat = 8'hA5;
      @(negedge clk);
      chk("l1_v0", d0_s.valid, 1);
      chk("l1_v1", d1_s.valid, 1);
      chk("l1_d0", d0_s.data, 32'h0011);
      chk("l1_d1", d1_s.data, 32'h1);
      tick();
      r_vld = 1'b0;
      @(negedge clk);
      chk("l2_d0s", d0_s.data, 32'hFFA5);
      chk("l2_d1s", d1_s.data, 32'h5);
      chk("l2_d0u", d0_u.data, 32'h00A5);
      tick();

      // Continuous stream: one datum per cycle.
      for (int i = 0; i < 6; i++) begin
         push(8'h40 + 8'(i));
         r_dat = 8'h40 + 8'(i);
         r_vld = 1'b1;
         @(negedge clk);
         chk($sformatf("cs_rdy_%0d", i), di_s.ready, 1);
         if (i > 0) begin
            chk($sformatf("cs_v_%0d", i), d0_s.valid, 1);
            chk($sformatf("cs_d_%0d", i), d0_s.data, 32'h40 + 32'(i) - 1);
         end
         tick();
      end
      r_vld = 1'b0;
      tick();
      tick();

      // Reset drops a registered datum.
      r_rdy0 = 1'b0; r_rdy1 = 1'b0;
      r_dat = 8'h33; r_vld = 1'b1;
      @(negedge clk);
      chk("rr_load_rdy", di_s.ready, 1);
      tick();
      r_vld = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rr_post_v0", d0_s.valid, 0);
      chk("rr_post_v1", d1_s.valid, 0);
      tick();
`endif

      // Back-to-back stream with random independent readies.
      for (int v = 1; v <= 12; v++) send(8'(v));
      r_vld = 1'b0;
      r_rdy0 = 1'b1; r_rdy1 = 1'b1;
      repeat (4) tick();
      chk("left_q0s", q0s.size(), 0);
      chk("left_q1s", q1s.size(), 0);
      chk("left_q0u", q0u.size(), 0);
      chk("left_q1u", q1u.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
